key_debounce_multi: RTL and testbench

- Parametrised multi-channel key debouncer; next generation of the single-key debouncer.
- Per channel: 2-flop synchroniser, debounced level, one-cycle press, release and long-press pulses, optional auto-repeat.
- Sits between board push-buttons and control FSMs; all channels are independent and share one clock.

---
 rtl/key_debounce_multi.sv | 165 ++++++++++++++++
 tb/tb_key_debounce_multi.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
// Multi-channel push-button conditioner. Each channel has a 2-flop
// synchroniser, a persistence-count debouncer, and a small FSM. The FSM
// turns the debounced level into one-cycle press, release, long-press and
// auto-repeat pulses. All channels run independently on one clock.
`timescale 1ns/1ps

module key_debounce_multi #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 15,
    parameter int LONG_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 200,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    // Debounce counter must be able to count up to DEBOUNCE_CYCLES-1.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    // One hold counter serves both the long-press and repeat intervals.
    localparam int HOLD_LR  = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_MAX = (HOLD_LR > 1) ? HOLD_LR : 1;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

    // Channel FSM encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Level the raw pin shows when the key is not pressed.
    localparam logic INACTIVE = ACTIVE_LOW;

    logic [NUM_KEYS-1:0] sync_a;
    logic [NUM_KEYS-1:0] sync_b;
    logic [NUM_KEYS-1:0] pressed;

    // Two-flop synchroniser; reset to the idle pin level so that a reset
    // never looks like a key event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= {NUM_KEYS{INACTIVE}};
            sync_b <= {NUM_KEYS{INACTIVE}};
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
        end
    end

    // Normalise polarity so that 1 always means "pressed" downstream.
    assign pressed = sync_b ^ {NUM_KEYS{ACTIVE_LOW}};

    for (genvar ch = 0; ch < NUM_KEYS; ch++) begin : g_chan
        logic [DB_W-1:0]   db_cnt;
        logic              level;
        logic              differs;
        logic              accept;
        logic              accept_press;
        logic              accept_release;
        logic [1:0]        state;
        logic [HOLD_W-1:0] hold_cnt;
        logic              press_r;
        logic              release_r;
        logic              long_r;
        logic              repeat_r;

        assign differs        = pressed[ch] ^ level;
        assign accept         = differs && (db_cnt == DB_LAST);
        assign accept_press   = accept && pressed[ch];
        assign accept_release = accept && !pressed[ch];

        // Debouncer: a new level is accepted only after it has been seen on
        // DEBOUNCE_CYCLES consecutive samples; any return to the current
        // level restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt <= '0;
                level  <= 1'b0;
            end else if (!differs) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                level  <= pressed[ch];
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

        // Event FSM: press -> long -> repeats, with release overriding any
        // long/repeat pulse that would have landed in the same cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= ST_IDLE;
                hold_cnt  <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                repeat_r  <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                repeat_r  <= 1'b0;
                if (accept_release) begin
                    state     <= ST_IDLE;
                    hold_cnt  <= '0;
                    release_r <= 1'b1;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (accept_press) begin
                                state    <= ST_HELD;
                                hold_cnt <= '0;
                                press_r  <= 1'b1;
                            end
                        end
                        ST_HELD: begin
                            if (hold_cnt == LONG_LAST) begin
                                state    <= ST_REPEAT;
                                hold_cnt <= '0;
                                long_r   <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            // With repeat disabled the channel parks here
                            // silently until release.
                            if (REPEAT_CYCLES > 0) begin
                                if (hold_cnt == REPEAT_LAST) begin
                                    hold_cnt <= '0;
                                    repeat_r <= 1'b1;
                                end else begin
                                    hold_cnt <= hold_cnt + HOLD_W'(1);
                                end
                            end
                        end
                        default: begin
                            state    <= ST_IDLE;
                            hold_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign key_level[ch]     = level;
        assign press_pulse[ch]   = press_r;
        assign release_pulse[ch] = release_r;
        assign long_pulse[ch]    = long_r;
        assign repeat_pulse[ch]  = repeat_r;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Testbench for key_debounce_multi: two instances (active-high with repeat,
// active-low with repeat disabled), a reference model computing expected
// events from sample windows and elapsed-time arithmetic, and a monitor that
// pops the expected-event queue whenever a DUT emits a pulse.
`timescale 1ns/1ps

module tb_key_debounce_multi;

    localparam int NK    = 4;
    localparam int DB    = 4;
    localparam int LC    = 20;
    localparam int REP_A = 5;
    localparam int REP_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NK-1:0] key_a, key_b;
    logic [NK-1:0] lvl_a, pp_a, rp_a, lp_a, rpt_a;
    logic [NK-1:0] lvl_b, pp_b, rp_b, lp_b, rpt_b;

    key_debounce_multi #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC),
                         .REPEAT_CYCLES(REP_A), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .key(key_a),
        .key_level(lvl_a), .press_pulse(pp_a), .release_pulse(rp_a),
        .long_pulse(lp_a), .repeat_pulse(rpt_a));

    key_debounce_multi #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC),
                         .REPEAT_CYCLES(REP_B), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .key(key_b),
        .key_level(lvl_b), .press_pulse(pp_b), .release_pulse(rp_b),
        .long_pulse(lp_b), .repeat_pulse(rpt_b));

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        int ch;
        int kind;   // 0 press, 1 release, 2 long, 3 repeat
    } evt_t;

    evt_t expq [2][$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ecount      = 0;        // rising edges since reset released
    bit   samp   [2][NK][$];      // pressed-state sampled at each edge
    bit   lvl_m  [2][NK];
    bit   held_m [2][NK];
    int   pedge  [2][NK];

    function automatic int rep_of(int d);
        return (d == 0) ? REP_A : REP_B;
    endfunction

    function automatic bit al_of(int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    // Pressed-state the debouncer evaluates at edge m: the pin value seen two
    // edges earlier, or "not pressed" while the synchroniser still holds its
    // reset value.
    function automatic bit dec(int d, int ch, int m);
        if (m < 3) return 1'b0;
        return samp[d][ch][m-3];
    endfunction

    function automatic string kname(int k);
        case (k)
            0: return "press";
            1: return "release";
            2: return "long";
            default: return "repeat";
        endcase
    endfunction

    task automatic push_evt(int d, int ch, int kind);
        evt_t e;
        e.edge_n = ecount;
        e.ch     = ch;
        e.kind   = kind;
        expq[d].push_back(e);
    endtask

    // Reference model: a level is accepted when the last DB evaluated samples
    // all disagree with it; long/repeat times follow from the press edge.
    always @(posedge clk) begin : model
        bit acc;
        int el;
        if (rst) begin
            ecount = 0;
            for (int d = 0; d < 2; d++)
                for (int ch = 0; ch < NK; ch++) begin
                    samp[d][ch].delete();
                    lvl_m[d][ch]  = 1'b0;
                    held_m[d][ch] = 1'b0;
                    pedge[d][ch]  = 0;
                end
        end else begin
            ecount++;
            for (int d = 0; d < 2; d++)
                for (int ch = 0; ch < NK; ch++) begin
                    samp[d][ch].push_back(((d == 0) ? key_a[ch] : key_b[ch]) ^ al_of(d));
                    acc = (ecount >= DB);
                    for (int m = ecount - DB + 1; m <= ecount; m++)
                        if (m >= 1 && dec(d, ch, m) == lvl_m[d][ch]) acc = 1'b0;
                    if (acc) begin
                        lvl_m[d][ch] = !lvl_m[d][ch];
                        if (lvl_m[d][ch]) begin
                            push_evt(d, ch, 0);
                            held_m[d][ch] = 1'b1;
                            pedge[d][ch]  = ecount;
                        end else begin
                            push_evt(d, ch, 1);
                            held_m[d][ch] = 1'b0;
                        end
                    end else if (held_m[d][ch]) begin
                        el = ecount - pedge[d][ch];
                        if (el == LC)
                            push_evt(d, ch, 2);
                        else if (rep_of(d) > 0 && el > LC && ((el - LC) % rep_of(d)) == 0)
                            push_evt(d, ch, 3);
                    end
                end
        end
    end

    // Monitor: compares levels every cycle and matches every emitted pulse
    // against the head of the expected-event queue.
    always @(negedge clk) begin : monitor
        logic [NK-1:0] o_lvl;
        logic [NK-1:0] o_p [4];
        logic [NK-1:0] exp_lvl;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                o_lvl = lvl_a; o_p[0] = pp_a; o_p[1] = rp_a; o_p[2] = lp_a; o_p[3] = rpt_a;
            end else begin
                o_lvl = lvl_b; o_p[0] = pp_b; o_p[1] = rp_b; o_p[2] = lp_b; o_p[3] = rpt_b;
            end
            if (rst) begin
                vectors++;
                if ({o_lvl, o_p[0], o_p[1], o_p[2], o_p[3]} != '0) begin
                    miscompares++;
                    $display("FAIL reset_outputs dut%0d: got lvl=%b p=%b r=%b l=%b rep=%b, want all 0",
                             d, o_lvl, o_p[0], o_p[1], o_p[2], o_p[3]);
                end
            end else begin
                for (int ch = 0; ch < NK; ch++) exp_lvl[ch] = lvl_m[d][ch];
                vectors++;
                if (o_lvl !== exp_lvl) begin
                    miscompares++;
                    $display("FAIL key_level dut%0d edge %0d: got %b want %b", d, ecount, o_lvl, exp_lvl);
                end
                while (expq[d].size() > 0 && expq[d][0].edge_n < ecount) begin
                    vectors++; miscompares++;
                    $display("FAIL missing_pulse dut%0d: got nothing, want %s ch%0d at edge %0d",
                             d, kname(expq[d][0].kind), expq[d][0].ch, expq[d][0].edge_n);
                    void'(expq[d].pop_front());
                end
                for (int ch = 0; ch < NK; ch++)
                    for (int k = 0; k < 4; k++)
                        if (o_p[k][ch] !== 1'b0) begin
                            vectors++;
                            if (expq[d].size() > 0 && expq[d][0].edge_n == ecount &&
                                expq[d][0].ch == ch && expq[d][0].kind == k) begin
                                void'(expq[d].pop_front());
                            end else begin
                                miscompares++;
                                if (expq[d].size() > 0)
                                    $display("FAIL pulse dut%0d: got %s ch%0d at edge %0d, want %s ch%0d at edge %0d",
                                             d, kname(k), ch, ecount, kname(expq[d][0].kind),
                                             expq[d][0].ch, expq[d][0].edge_n);
                                else
                                    $display("FAIL pulse dut%0d: got %s ch%0d at edge %0d, want no pulse",
                                             d, kname(k), ch, ecount);
                            end
                        end
                while (expq[d].size() > 0 && expq[d][0].edge_n == ecount) begin
                    vectors++; miscompares++;
                    $display("FAIL missing_pulse dut%0d: got nothing, want %s ch%0d at edge %0d",
                             d, kname(expq[d][0].kind), expq[d][0].ch, expq[d][0].edge_n);
                    void'(expq[d].pop_front());
                end
            end
        end
    end

    task automatic dcheck(string name, logic [NK-1:0] got, logic [NK-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Stimulus drives "pressed" values; dut_b sees them inverted on its pins.
    task automatic set_a(int ch, bit v);
        key_a[ch] = v;
    endtask

    task automatic set_b(int ch, bit v);
        key_b[ch] = ~v;
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    bit pa [NK];
    bit pb [NK];
    int bounce [10] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 0};

    initial begin
        key_a = '0;
        key_b = '1;
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // ch0 pressed before edge 1: press lands on edge 2+DB = 6.
        set_a(0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 5) dcheck("press_before_edge6", pp_a, 4'b0000);
            if (i == 6) begin
                dcheck("press_edge6", pp_a, 4'b0001);
                dcheck("level_edge6", lvl_a, 4'b0001);
                dcheck("no_spurious_b", pp_b | rp_b, 4'b0000);
            end
            if (i == 7) dcheck("press_one_cycle", pp_a, 4'b0000);
        end

        // ch1 bounce (3,1,2 high) then stable high.
        foreach (bounce[i]) begin
            set_a(1, bounce[i] != 0);
            tick(1);
        end
        set_a(1, 1'b1);
        tick(12);

        // ch2 long hold with repeats; dut_b ch0 long hold, ch3 short press.
        set_a(2, 1'b1);
        set_b(0, 1'b1);
        set_b(3, 1'b1);
        tick(12);
        set_b(3, 1'b0);
        tick(34);
        set_a(2, 1'b0);
        tick(70);
        set_b(0, 1'b0);
        set_a(1, 1'b0);
        tick(20);

        // Reset while ch0 is in its repeat phase with the key still held.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        dcheck("async_reset_a", lvl_a | pp_a | rp_a | lp_a | rpt_a, 4'b0000);
        dcheck("async_reset_b", lvl_b | pp_b | rp_b | lp_b | rpt_b, 4'b0000);
        tick(3);
        rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 6)  dcheck("repress_edge6", pp_a, 4'b0001);
            if (i == 25) dcheck("relong_before", lp_a, 4'b0000);
            if (i == 26) dcheck("relong_edge26", lp_a, 4'b0001);
        end
        set_a(0, 1'b0);
        tick(20);

        // Randomised toggling on every channel of both instances.
        for (int ch = 0; ch < NK; ch++) begin
            pa[ch] = 1'b0;
            pb[ch] = 1'b0;
        end
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int ch = 0; ch < NK; ch++) begin
                if ($urandom_range(0, 99) < 3) pa[ch] = !pa[ch];
                if ($urandom_range(0, 99) < 3) pb[ch] = !pb[ch];
                set_a(ch, pa[ch]);
                set_b(ch, pb[ch]);
            end
            tick(1);
        end
        for (int ch = 0; ch < NK; ch++) begin
            set_a(ch, 1'b0);
            set_b(ch, 1'b0);
        end
        tick(60);

        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (expq[d].size() != 0) begin
                miscompares++;
                $display("FAIL drain dut%0d: got %0d pending events, want 0", d, expq[d].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
